// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-stage FSM states for the ALU decoder/execute pair.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  // sll/srl/sra share the top two code bits
  function automatic logic is_shift(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl[2] & ctrl[1];
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: load performs the first shift, each step one more.
module alu_serial_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic [WIDTH-1:0]   first_c,
  output logic [WIDTH-1:0]   next_c,
  output logic               done_c
);

  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic               left_q;
  logic               arith_q;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic lft,
                                              input logic ar);
    if (lft) return {v[WIDTH-2:0], 1'b0};
    return {ar & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  assign first_c = shift1(data, left, arith);
  assign next_c  = shift1(work, left_q, arith_q);
  assign done_c  = step & (cnt == SHAMT_W'(1));

  // cnt holds the shifts still outstanding after the current working value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      work    <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      work    <= first_c;
      cnt     <= shamt - SHAMT_W'(1);
      left_q  <= left;
      arith_q <= arith;
    end else if (step && cnt != '0) begin
      work <= next_c;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready handshake; shifts are serial unless
// ALU_ITER_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic             arith,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  alu_state_t         state, state_next;
  logic [WIDTH-1:0]   result_next;
  logic               out_valid_next;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_c;

  assign shamt    = src_b[SHAMT_W-1:0];
  assign in_ready = (state == IDLE);

  // Single-cycle ops
  always_comb begin
    alu_c = '0;
    case (alu_ctrl)
      ALU_ADD: alu_c = src_a + src_b;
      ALU_SUB: alu_c = src_a - src_b;
      ALU_AND: alu_c = src_a & src_b;
      ALU_OR:  alu_c = src_a | src_b;
      ALU_XOR: alu_c = src_a ^ src_b;
      ALU_SLT: alu_c = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_c = '0;
    endcase
  end

`ifdef ALU_ITER_BARREL_SHIFT_EN
  logic [WIDTH-1:0] barrel_c;

  always_comb begin
    if (alu_ctrl == ALU_SLL) barrel_c = src_a << shamt;
    else if (arith)          barrel_c = WIDTH'($signed(src_a) >>> shamt);
    else                     barrel_c = src_a >> shamt;
  end
`else
  logic             sh_load;
  logic             sh_step;
  logic [WIDTH-1:0] sh_first_c;
  logic [WIDTH-1:0] sh_next_c;
  logic             sh_done_c;

  alu_serial_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sh_load),
    .step    (sh_step),
    .data    (src_a),
    .shamt   (shamt),
    .left    (alu_ctrl == ALU_SLL),
    .arith   (arith),
    .first_c (sh_first_c),
    .next_c  (sh_next_c),
    .done_c  (sh_done_c)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      result    <= result_next;
      zero      <= (result_next == '0);
    end
  end

  always_comb begin
    state_next     = state;
    result_next    = result;
    out_valid_next = out_valid;
`ifndef ALU_ITER_BARREL_SHIFT_EN
    sh_load        = 1'b0;
    sh_step        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_shift(alu_ctrl)) begin
            result_next    = alu_c;
            state_next     = DONE;
            out_valid_next = 1'b1;
          end else begin
`ifdef ALU_ITER_BARREL_SHIFT_EN
            result_next    = barrel_c;
            state_next     = DONE;
            out_valid_next = 1'b1;
`else
            // first shift lands on the accept edge, so latency is max(shamt,1)
            if (shamt == '0) begin
              result_next    = src_a;
              state_next     = DONE;
              out_valid_next = 1'b1;
            end else if (shamt == SHAMT_W'(1)) begin
              result_next    = sh_first_c;
              state_next     = DONE;
              out_valid_next = 1'b1;
            end else begin
              sh_load    = 1'b1;
              state_next = SHIFT;
            end
`endif
          end
        end
      end
      SHIFT: begin
`ifdef ALU_ITER_BARREL_SHIFT_EN
        state_next = IDLE;
`else
        sh_step = 1'b1;
        if (sh_done_c) begin
          result_next    = sh_next_c;
          state_next     = DONE;
          out_valid_next = 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
